// File: rtl/mips32a_pkg.sv
// Shared definitions for the mips32a program loader and its benches.
//   ld_state_e : loader FSM state encoding
//   HDR_BYTES  : number of length-header bytes ahead of the instruction words
//   OP_HLT     : opcode of the core's halt instruction
package mips32a_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CKSUM,
    ST_RELEASE,
    ST_RUN,
    ST_ERROR
  } ld_state_e;

  localparam int unsigned HDR_BYTES = 2;
  localparam logic [5:0]  OP_HLT    = 6'h3f;

endpackage

// File: rtl/mips32a_word_pack.sv
// Byte-to-word assembler, big-endian (first byte lands in bits 31:24).
// Ports:
//   clk1, rst     : clock, async active-high reset
//   clear         : drops any partial word and zeroes the shift register
//   accept        : byte_in is consumed this cycle
//   byte_in       : stream byte
//   word          : registered shift register; holds the full word while word_valid is high
//   word_valid    : registered one-cycle pulse, the cycle after the 4th byte
//   word_done_c   : combinational, high while the 4th byte of a word is being accepted
module mips32a_word_pack (
  input  logic        clk1,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        word_done_c
);

  logic [1:0] idx;

  assign word_done_c = accept && (idx == 2'd3);

  // Shift in bytes MSB-first; the 2-bit index wraps naturally after each word.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      idx        <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else if (clear) begin
      idx        <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_done_c;
      if (accept) begin
        word <= {word[23:0], byte_in};
        idx  <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mips32a_prog_loader.sv
// Program loader for the mips32a core: receives a length header plus big-endian
// instruction words, writes them to instruction memory from word 0, releases the
// core with a pc-clear pulse and re-arms when the core halts.
// Optional feature macro: MIPS32A_LOADER_CKSUM_EN (trailing XOR checksum byte,
// CKSUM state and err_cksum port).
// Ports:
//   clk1, rst                 : clock, async active-high reset
//   start                     : begins a load (honoured in IDLE/ERROR only)
//   s_valid, s_ready, s_data  : byte stream handshake
//   mem_we, mem_addr, mem_wdata : registered instruction-memory write
//   core_hold, core_pc_clr, core_halted : core control / status
//   busy, done                : loader status, done pulses when the core halts
//   err_len, err_cksum        : sticky error flags
module mips32a_prog_loader
  import mips32a_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              core_pc_clr,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic              err_len
`ifdef MIPS32A_LOADER_CKSUM_EN
  ,
  output logic              err_cksum
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  ld_state_e         state, state_next;
  logic [7:0]        len_hi;
  logic [ADDR_W-1:0] last_idx;
  logic [CNT_W-1:0]  word_cnt;
  logic [15:0]       len_c;
  logic              byte_ok_c;
  logic              start_ok_c;
  logic              len_ok_c;
  logic              last_word_c;
  logic              pack_clear_c;
  logic              pack_accept_c;
  logic              word_done_c;
`ifdef MIPS32A_LOADER_CKSUM_EN
  logic [7:0]        cksum;
`endif

  assign byte_ok_c     = s_valid && s_ready;
  assign start_ok_c    = start && ((state == ST_IDLE) || (state == ST_ERROR));
  assign len_c         = {len_hi, s_data};
  assign len_ok_c      = (len_c != 16'd0) && (32'(len_c) <= MAX_WORDS);
  assign last_word_c   = (word_cnt == {1'b0, last_idx});
  assign pack_clear_c  = (state != ST_DATA);
  assign pack_accept_c = byte_ok_c && (state == ST_DATA);

  mips32a_word_pack u_pack (
    .clk1        (clk1),
    .rst         (rst),
    .clear       (pack_clear_c),
    .accept      (pack_accept_c),
    .byte_in     (s_data),
    .word        (mem_wdata),
    .word_valid  (mem_we),
    .word_done_c (word_done_c)
  );

  // State register.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_LEN_HI;
      ST_LEN_HI:  if (byte_ok_c) state_next = ST_LEN_LO;
      ST_LEN_LO:  if (byte_ok_c) state_next = len_ok_c ? ST_DATA : ST_ERROR;
      ST_DATA: begin
        if (word_done_c && last_word_c) begin
`ifdef MIPS32A_LOADER_CKSUM_EN
          state_next = ST_CKSUM;
`else
          state_next = ST_RELEASE;
`endif
        end
      end
`ifdef MIPS32A_LOADER_CKSUM_EN
      ST_CKSUM:   if (byte_ok_c) state_next = (s_data == cksum) ? ST_RELEASE : ST_ERROR;
`endif
      ST_RELEASE: state_next = ST_RUN;
      ST_RUN:     if (core_halted) state_next = ST_IDLE;
      ST_ERROR:   if (start) state_next = ST_LEN_HI;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Registered outputs and datapath; state-decoded outputs track state_next so
  // they line up with the state register.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      core_hold   <= 1'b1;
      core_pc_clr <= 1'b0;
      done        <= 1'b0;
      err_len     <= 1'b0;
      mem_addr    <= '0;
      word_cnt    <= '0;
      last_idx    <= '0;
      len_hi      <= 8'd0;
    end else begin
      s_ready     <= (state_next == ST_LEN_HI) || (state_next == ST_LEN_LO) ||
                     (state_next == ST_DATA)   || (state_next == ST_CKSUM);
      busy        <= (state_next != ST_IDLE) && (state_next != ST_ERROR);
      core_hold   <= (state_next != ST_RUN);
      core_pc_clr <= (state_next == ST_RELEASE);
      done        <= (state == ST_RUN) && core_halted;

      if (start_ok_c) begin
        err_len  <= 1'b0;
        word_cnt <= '0;
      end
      if ((state == ST_LEN_HI) && byte_ok_c) len_hi <= s_data;
      if ((state == ST_LEN_LO) && byte_ok_c) begin
        if (len_ok_c) last_idx <= ADDR_W'(len_c - 16'd1);
        else          err_len  <= 1'b1;
      end
      // Address is captured with the completing byte so it lines up with mem_we.
      if (word_done_c) begin
        mem_addr <= word_cnt[ADDR_W-1:0];
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

`ifdef MIPS32A_LOADER_CKSUM_EN
  // Running XOR of data bytes and the sticky mismatch flag.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      cksum     <= 8'd0;
      err_cksum <= 1'b0;
    end else begin
      if (start_ok_c) begin
        cksum     <= 8'd0;
        err_cksum <= 1'b0;
      end else if (pack_accept_c) begin
        cksum <= cksum ^ s_data;
      end
      if ((state == ST_CKSUM) && byte_ok_c && (s_data != cksum)) err_cksum <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mips32a_prog_loader.sv
// Self-checking bench for mips32a_prog_loader (works with or without
// MIPS32A_LOADER_CKSUM_EN). A reference model builds each byte stream from a
// word list and predicts the memory write sequence and control timing.
module tb_mips32a_prog_loader;

  localparam int unsigned AW   = 10;
  localparam int unsigned MAXW = 1024;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'd0;
  logic          core_halted = 1'b0;
  logic          s_ready, mem_we, core_hold, core_pc_clr, busy, done, err_len;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
`ifdef MIPS32A_LOADER_CKSUM_EN
  logic          err_cksum;
`endif

  mips32a_prog_loader #(.ADDR_W(AW), .MAX_WORDS(MAXW)) dut (
    .clk1(clk1), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .core_pc_clr(core_pc_clr), .core_halted(core_halted),
    .busy(busy), .done(done), .err_len(err_len)
`ifdef MIPS32A_LOADER_CKSUM_EN
    , .err_cksum(err_cksum)
`endif
  );

  always #5 clk1 = ~clk1;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          pc_clr_cnt = 0;
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] word_q[$];
  logic [7:0]  byte_q[$];

  always @(posedge clk1) cyc <= cyc + 1;

  // Memory-side monitor: every cycle with mem_we high is one write.
  always @(negedge clk1) begin
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_wdata);
    end
    if (core_pc_clr) pc_clr_cnt <= pc_clr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    rst = 1'b0;
  endtask

  // Reference stream: 16-bit length, words MSB first, optional XOR checksum.
  task automatic build(input logic [15:0] n, input bit bad_ck);
    logic [7:0] ck;
    logic [7:0] x;
    byte_q.delete();
    byte_q.push_back(n[15:8]);
    byte_q.push_back(n[7:0]);
    ck = 8'd0;
    foreach (word_q[i]) begin
      for (int b = 3; b >= 0; b--) begin
        x = 8'(word_q[i] >> (8 * b));
        byte_q.push_back(x);
        ck ^= x;
      end
    end
`ifdef MIPS32A_LOADER_CKSUM_EN
    byte_q.push_back(bad_ck ? (ck ^ 8'h01) : ck);
`else
    if (bad_ck) ck = 8'd0;
`endif
  endtask

  task automatic rand_words(input int n);
    word_q.delete();
    for (int i = 0; i < n; i++) word_q.push_back($urandom);
  endtask

  // Pulse start; returns just after the edge that samples it.
  task automatic load_start(output int edge_cyc);
    @(negedge clk1);
    start = 1'b1;
    @(posedge clk1);
    edge_cyc = cyc + 1;
    #1 start = 1'b0;
  endtask

  // Presents one byte (after an optional random gap) until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap_max, input bit st, output bit ok);
    int   g;
    logic rdy;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    @(negedge clk1);
    s_valid = 1'b0;
    repeat (g) @(negedge clk1);
    s_valid = 1'b1;
    s_data  = b;
    start   = st;
    ok      = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      rdy = s_ready;
      @(posedge clk1);
      if (rdy) ok = 1'b1;
      else begin
        #1 start = 1'b0;
        @(negedge clk1);
      end
    end
    #1;
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  // Sends byte_q; ends 1 time unit after the edge that takes the final byte.
  task automatic send_all(input string tag, input int gap_max, input int start_idx);
    bit ok;
    ok = 1'b1;
    foreach (byte_q[i]) begin
      send_byte(byte_q[i], gap_max, (i == start_idx), ok);
      if (!ok) break;
    end
    chk({tag, "_stream_taken"}, 32'(ok), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int base, input int n);
    int mism;
    mism = 0;
    chk({tag, "_wr_count"}, 32'(wr_addr_q.size() - base), 32'(n));
    for (int i = 0; i < n && (base + i) < wr_addr_q.size(); i++) begin
      if (wr_addr_q[base + i] != i || wr_data_q[base + i] !== word_q[i]) mism++;
    end
    chk({tag, "_wr_content_mism"}, 32'(mism), 32'd0);
  endtask

  // Release/run phase following the final byte; halt raised halt_dly cycles into RUN.
  task automatic run_core(input string tag, input int halt_dly, input bit st_in_run);
    chk({tag, "_pc_clr_pulse"}, 32'(core_pc_clr), 32'd1);
    chk({tag, "_hold_in_release"}, 32'(core_hold), 32'd1);
    @(posedge clk1); #1;
    chk({tag, "_pc_clr_end"}, 32'(core_pc_clr), 32'd0);
    chk({tag, "_hold_fall"}, 32'(core_hold), 32'd0);
    for (int i = 0; i < halt_dly; i++) begin
      @(negedge clk1);
      start = st_in_run && (i == 1);
    end
    chk({tag, "_hold_low_in_run"}, 32'(core_hold), 32'd0);
    chk({tag, "_no_early_done"}, 32'(done), 32'd0);
    @(negedge clk1);
    start = 1'b0;
    core_halted = 1'b1;
    @(posedge clk1); #1;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hold_after_halt"}, 32'(core_hold), 32'd1);
    chk({tag, "_busy_after_halt"}, 32'(busy), 32'd0);
    @(negedge clk1);
    core_halted = 1'b0;
    @(posedge clk1); #1;
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int base, e0, pcs;

    do_reset();
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_pc_clr", 32'(core_pc_clr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
`ifdef MIPS32A_LOADER_CKSUM_EN
    chk("rst_err_cksum", 32'(err_cksum), 32'd0);
`endif

    // Happy path with the two-word reference program.
    word_q = '{32'h2801000a, 32'h28020014};
    build(16'd2, 1'b0);
`ifdef MIPS32A_LOADER_CKSUM_EN
    chk("ref_cksum_byte", 32'(byte_q[byte_q.size() - 1]), 32'h1d);
`endif
    base = wr_addr_q.size();
    load_start(e0);
    send_all("happy", 0, -1);
    chk("happy_byte_latency", 32'(cyc - e0), 32'(byte_q.size()));
    run_core("happy", 5, 1'b0);
    check_writes("happy", base, 2);

`ifdef MIPS32A_LOADER_CKSUM_EN
    // Corrupted checksum: no release, sticky flag, cleared by start.
    build(16'd2, 1'b1);
    chk("bad_cksum_byte", 32'(byte_q[byte_q.size() - 1]), 32'h1c);
    pcs = pc_clr_cnt;
    load_start(e0);
    send_all("badck", 0, -1);
    chk("badck_err", 32'(err_cksum), 32'd1);
    chk("badck_busy", 32'(busy), 32'd0);
    repeat (4) @(posedge clk1);
    #1;
    chk("badck_no_release", 32'(pc_clr_cnt - pcs), 32'd0);
    chk("badck_hold", 32'(core_hold), 32'd1);
    load_start(e0);
    chk("badck_cleared", 32'(err_cksum), 32'd0);
    chk("badck_restart_ready", 32'(s_ready), 32'd1);
    do_reset();
`else
    pcs = pc_clr_cnt;
`endif

    // Illegal lengths: zero and MAX_WORDS+1.
    for (int k = 0; k < 2; k++) begin
      word_q.delete();
      build((k == 0) ? 16'd0 : 16'(MAXW + 1), 1'b0);
      base = wr_addr_q.size();
      pcs  = pc_clr_cnt;
      load_start(e0);
      send_all("badlen", 0, -1);
      chk("badlen_err", 32'(err_len), 32'd1);
      chk("badlen_s_ready", 32'(s_ready), 32'd0);
      chk("badlen_busy", 32'(busy), 32'd0);
      repeat (4) @(posedge clk1);
      #1;
      chk("badlen_no_write", 32'(wr_addr_q.size() - base), 32'd0);
      chk("badlen_no_release", 32'(pc_clr_cnt - pcs), 32'd0);
      load_start(e0);
      chk("badlen_cleared", 32'(err_len), 32'd0);
      do_reset();
    end

    // Maximum length.
    rand_words(MAXW);
    build(16'(MAXW), 1'b0);
    base = wr_addr_q.size();
    load_start(e0);
    send_all("maxlen", 0, -1);
    run_core("maxlen", 2, 1'b0);
    check_writes("maxlen", base, MAXW);
    chk("maxlen_last_addr", 32'(wr_addr_q[wr_addr_q.size() - 1]), 32'(MAXW - 1));

    // Nine words, gap-free then with random valid gaps.
    rand_words(9);
    build(16'd9, 1'b0);
    for (int k = 0; k < 2; k++) begin
      base = wr_addr_q.size();
      load_start(e0);
      send_all("gaps", (k == 0) ? 0 : 3, -1);
      run_core("gaps", 3, 1'b0);
      check_writes("gaps", base, 9);
    end

    // Reset after byte 2 of word 3 of a five-word load.
    rand_words(5);
    build(16'd5, 1'b0);
    while (byte_q.size() > 2 + 4 * 3 + 2) void'(byte_q.pop_back());
    base = wr_addr_q.size();
    load_start(e0);
    send_all("midrst", 0, -1);
    rst = 1'b1;
    #1;
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_hold", 32'(core_hold), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pc_clr", 32'(core_pc_clr), 32'd0);
    do_reset();
    check_writes("midrst", base, 3);
    rand_words(3);
    build(16'd3, 1'b0);
    base = wr_addr_q.size();
    load_start(e0);
    send_all("afterrst", 0, -1);
    chk("afterrst_byte_latency", 32'(cyc - e0), 32'(byte_q.size()));
    run_core("afterrst", 4, 1'b0);
    check_writes("afterrst", base, 3);

    // Stray start pulses during DATA and RUN are ignored.
    rand_words(4);
    build(16'd4, 1'b0);
    base = wr_addr_q.size();
    load_start(e0);
    send_all("ignstart", 0, 7);
    chk("ignstart_byte_latency", 32'(cyc - e0), 32'(byte_q.size()));
    run_core("ignstart", 5, 1'b1);
    check_writes("ignstart", base, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
